// File: rtl/loader_pkg.sv
// Shared state encoding and framing constants for the boot-time program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        StHdr   = 3'd0,
        StLoad  = 3'd1,
        StWrite = 3'd2,
        StCheck = 3'd3,
        StDone  = 3'd4,
        StError = 3'd5
    } state_e;

    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface prog_loader_if #(
    parameter int unsigned ADDR_WIDTH = 10
);

    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/byte_assembler.sv
// MSB-first 4-byte shift register; word_full flags the byte that completes a word.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic [31:0] word_next,
    output logic        word_full
);

    localparam int unsigned IdxW = $clog2(WORD_BYTES);

    logic [31:0]     word_q;
    logic [IdxW-1:0] idx_q;

    assign word_next = {word_q[23:0], in_byte};
    assign word_full = take && (idx_q == IdxW'(WORD_BYTES - 1));
    assign word      = word_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (clear) begin
            idx_q  <= '0;
        end else if (take) begin
            word_q <= word_next;
            idx_q  <= idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory and
// holds the CPU in reset until the image is verified.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    prog_loader_if.slave        bus,
    output logic                cpu_reset_n,
    output logic                done,
    output logic                error,
    output logic [ADDR_WIDTH:0] word_cnt
);

    localparam longint unsigned Capacity = (64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

    state_e                state_q, state_d;
    logic [31:0]           n_q, n_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [7:0]            csum_q, csum_d;
    logic                  ready_q, done_q, error_q, cpu_rst_q;

    logic        take, rearm, word_full;
    logic [31:0] word, word_next;

    assign take  = bus.in_valid && ready_q;
    assign rearm = start && ((state_q == StDone) || (state_q == StError));

    byte_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (rearm),
        .take      (take),
        .in_byte   (bus.in_data),
        .word      (word),
        .word_next (word_next),
        .word_full (word_full)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        case (state_q)
            StHdr: begin
                if (word_full) begin
                    n_d = word_next;
                    if (64'(word_next) > Capacity) state_d = StError;
                    else if (word_next == 32'd0)   state_d = StCheck;
                    else                           state_d = StLoad;
                end
            end
            StLoad: begin
                if (take)      csum_d  = csum_q ^ bus.in_data;
                if (word_full) state_d = StWrite;
            end
            StWrite: begin
                addr_d  = addr_q + 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = (32'(cnt_q) + 32'd1 == n_q) ? StCheck : StLoad;
            end
            StCheck: begin
                if (take) state_d = (bus.in_data == csum_q) ? StDone : StError;
            end
            StDone, StError: begin
                if (start) begin
                    state_d = StHdr;
                    cnt_d   = '0;
                    csum_d  = '0;
                    addr_d  = BaseAddr;
                end
            end
            default: state_d = StHdr;
        endcase
    end

    // Status outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StHdr;
            n_q       <= '0;
            addr_q    <= BaseAddr;
            cnt_q     <= '0;
            csum_q    <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cpu_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            ready_q   <= (state_d == StHdr) || (state_d == StLoad) || (state_d == StCheck);
            done_q    <= (state_d == StDone);
            error_q   <= (state_d == StError);
            cpu_rst_q <= (state_d == StDone);
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.imem_we    = (state_q == StWrite);
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = word;
    assign cpu_reset_n    = cpu_rst_q;
    assign done           = done_q;
    assign error          = error_q;
    assign word_cnt       = cnt_q;

endmodule
